// File: rtl/bcd_sequential_converter_if.sv
// Handshake and result bundle between the output-port value source and the
// bit-serial binary-to-BCD converter that drives the seven-segment decoders.
`timescale 1ns/1ps

interface bcd_sequential_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output binary,
    input  busy,
    input  done,
    input  overflow,
    input  bcd
  );

  modport slave (
    input  start,
    input  binary,
    output busy,
    output done,
    output overflow,
    output bcd
  );
endinterface

// File: rtl/bcd_sequential_converter.sv
// Bit-serial double-dabble converter: one input bit per clock, result digits
// registered and held stable between conversions for the display stage.
`timescale 1ns/1ps

module bcd_sequential_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  bcd_sequential_converter_if.slave   bus
);

  localparam int INT_DIGITS = (WIDTH + 2) / 3;
  localparam int SW         = 4 * INT_DIGITS;
  localparam int CW         = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [SW-1:0]        r_scratch;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [4*DIGITS-1:0]  r_bcd;

  logic [SW-1:0]        w_adjusted;
  logic [SW-1:0]        w_scratch_next;
  logic [4*DIGITS-1:0]  w_bcd_next;
  logic                 w_overflow_next;

  // NOTE: the default copy on the first line keeps digits that need no
  // correction from turning into latches.
  always_comb begin
    w_adjusted = r_scratch;
    for (int k = 0; k < INT_DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adjusted[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_scratch_next = {w_adjusted[SW-2:0], r_shift[WIDTH-1]};

  // Result taps come from the post-shift value so digits land on the final
  // shift edge, in the same cycle that done is high.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k < INT_DIGITS) begin : g_used
      assign w_bcd_next[4*k +: 4] = w_scratch_next[4*k +: 4];
    end else begin : g_pad
      assign w_bcd_next[4*k +: 4] = 4'd0;
    end
  end

  if (INT_DIGITS > DIGITS) begin : g_ovf
    assign w_overflow_next = |w_scratch_next[SW-1:4*DIGITS];
  end else begin : g_no_ovf
    assign w_overflow_next = 1'b0;
  end

  // NOTE: every register, scratch included, is cleared by reset so an aborted
  // conversion leaves nothing behind for the next one or the display.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees the
      // pre-edge values regardless of statement order.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.binary;
            r_scratch <= '0;
            r_count   <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= r_shift << 1;
          r_count   <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_bcd      <= w_bcd_next;
            r_overflow <= w_overflow_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;
  assign bus.bcd      = r_bcd;

endmodule

// File: tb/tb_bcd_sequential_converter.sv
// Scoreboard bench: stimulus pushes decimal-model expectations, a negedge
// monitor pops and compares on every done pulse and polices result holding.
`timescale 1ns/1ps

module tb_bcd_sequential_converter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;
  localparam int LAT    = WIDTH + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  bcd_sequential_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_sequential_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          n_done   = 0;
  logic        tb_rst_q = 1'b0;
  logic [31:0] prev_bcd;
  logic        prev_ovf;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    tb_rst_q <= reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden model: plain decimal arithmetic on the full value.
  function automatic void ref_model(input logic [31:0] v, output logic [31:0] b, output logic o);
    longint unsigned x;
    x = 64'(v);
    b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    o = (x != 0);
  endfunction

  task automatic expect_result(input logic [31:0] v, input int sc);
    exp_t e;
    ref_model(v, e.bcd, e.ovf);
    e.start_cyc = sc;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (tb_rst_q) begin
      if (bus.done === 1'b1) begin
        n_done++;
        check("result_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bcd", 64'(bus.bcd), 64'(e.bcd));
          check("overflow", 64'(bus.overflow), 64'(e.ovf));
          check("latency", 64'(cyc - e.start_cyc), 64'(LAT));
          for (int k = 0; k < DIGITS; k++)
            check("nibble_le9", 64'(bus.bcd[4*k +: 4] <= 4'd9), 64'd1);
        end
      end else begin
        check("bcd_hold", 64'(bus.bcd), 64'(prev_bcd));
        check("ovf_hold", 64'(bus.overflow), 64'(prev_ovf));
      end
    end
    prev_bcd = bus.bcd;
    prev_ovf = bus.overflow;
  end

  task automatic wait_done(inout int busy_cnt);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) return;
    end
    check("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic run_one(input logic [31:0] v, output int busy_cnt);
    bus.start  = 1'b1;
    bus.binary = v;
    expect_result(v, cyc);
    @(negedge clock);
    bus.start = 1'b0;
    busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
    wait_done(busy_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc;
    int          d0;
    logic [31:0] v;

    bus.start  = 1'b0;
    bus.binary = '0;
    reset      = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_bcd", 64'(bus.bcd), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_one(32'd0, bc);
    check("busy_cycles", 64'(bc), 64'(WIDTH));
    @(negedge clock);

    // Previous result must stay visible mid-conversion.
    bus.start  = 1'b1;
    bus.binary = 32'd12345678;
    expect_result(32'd12345678, cyc);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (15) @(negedge clock);
    check("bcd_mid_conv", 64'(bus.bcd), 64'h0);
    check("busy_mid_conv", 64'(bus.busy), 64'd1);
    bc = 0;
    wait_done(bc);
    @(negedge clock);

    run_one(32'd99999999, bc);
    @(negedge clock);
    run_one(32'd100000000, bc);
    @(negedge clock);
    run_one(32'hFFFF_FFFF, bc);
    check("ovf_after_max", 64'(bus.overflow), 64'd1);
    @(negedge clock);

    // Start during conversion is ignored.
    d0         = n_done;
    bus.start  = 1'b1;
    bus.binary = 32'd11111111;
    expect_result(32'd11111111, cyc);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    bus.start  = 1'b1;
    bus.binary = 32'd22222222;
    @(negedge clock);
    bus.start  = 1'b0;
    bus.binary = 32'd33333333;
    bc = 0;
    wait_done(bc);
    repeat (40) @(negedge clock);
    check("done_count", 64'(n_done - d0), 64'd1);

    // Reset in the middle of a conversion.
    d0         = n_done;
    bus.start  = 1'b1;
    bus.binary = 32'd777;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_bcd", 64'(bus.bcd), 64'd0);
    check("midrst_ovf", 64'(bus.overflow), 64'd0);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("midrst_no_done", 64'(n_done - d0), 64'd0);
    run_one(32'd42, bc);
    @(negedge clock);

    // Random sweep with start held high.
    v          = $urandom;
    bus.start  = 1'b1;
    bus.binary = v;
    expect_result(v, cyc);
    for (int i = 0; i < 1000; i++) begin
      bc = 0;
      wait_done(bc);
      if (i < 999) begin
        case (i % 4)
          0:       v = $urandom;
          1:       v = $urandom_range(0, 99999999);
          2:       v = $urandom_range(0, 9999);
          default: v = 32'd99999990 + $urandom_range(0, 20);
        endcase
        bus.binary = v;
        expect_result(v, cyc + 1);
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (40) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
